// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD 7-segment scan controller with frame-synchronous shadow loading.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic                    run_q, run_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic                    boundary;

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;
    logic [3:0]              nibble;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q           <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= '0;
            digit_sel_q     <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            run_q           <= run_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            digit_sel_q     <= digit_sel_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // load is a one-cycle strobe with no back-pressure: digits_in is taken on every edge where load=1.
    always_comb begin
        run_d           = run_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        boundary        = 1'b0;
        if (!en) begin
            run_d = 1'b0;
            cnt_d = '0;
            idx_d = '0;
            if (load) begin
                active_d        = digits_in;
                pending_valid_d = 1'b0;
            end
        end else if (!run_q) begin
            // First enabled edge presents cnt=0 of digit 0, so the blank phase is seen in full.
            run_d = 1'b1;
            cnt_d = '0;
            idx_d = '0;
            if (load) begin
                pending_d       = digits_in;
                pending_valid_d = 1'b1;
            end
        end else begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (boundary) begin
                if (load) begin
                    active_d = digits_in;
                end else if (pending_valid_q) begin
                    active_d = pending_q;
                end
                pending_valid_d = 1'b0;
            end else if (load) begin
                pending_d       = digits_in;
                pending_valid_d = 1'b1;
            end
        end
    end

    // Outputs are computed from next state and registered, so they describe the slot cycle being entered.
    always_comb begin
        nibble       = active_d[{idx_d, 2'b00} +: 4];
        seg_d        = '0;
        digit_sel_d  = '0;
        frame_done_d = boundary;
        if (en) begin
            seg_d = decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_d != '0) && ((active_d >> {idx_d, 2'b00}) == '0)) begin
                seg_d = '0;
            end
`endif
            if (int'(cnt_d) >= BLANK_CYCLES) begin
                digit_sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
            end
        end
    end

    assign seg        = seg_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: directed scenarios then random traffic vs a timeline model.
module tb_bcd_display_scanner;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // model: t = cycles since scanning (re)started, -1 when dark
  int          t = -1;
  logic [15:0] shown = '0;
  logic [15:0] pend = '0;
  bit          pend_v = 1'b0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits_in  (digits_in),
    .load       (load),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  // clock
  always #5 clk = ~clk;

  // predict the outputs after the next edge from the current inputs
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_sel;
    logic       e_fd;
    logic [3:0] v;
    int         d;
    int         off;
    e_seg = '0;
    e_sel = '0;
    e_fd  = 1'b0;
    if (rst) begin
      t = -1;
      shown = '0;
      pend = '0;
      pend_v = 1'b0;
    end else if (!en) begin
      t = -1;
      if (load) begin
        shown = digits_in;
        pend_v = 1'b0;
      end
    end else begin
      t = t + 1;
      e_fd = (t > 0) && (t % FRAME == 0);
      if (e_fd) begin
        if (load) shown = digits_in;
        else if (pend_v) shown = pend;
        pend_v = 1'b0;
      end else if (load) begin
        pend = digits_in;
        pend_v = 1'b1;
      end
      d   = (t / R) % N;
      off = t % R;
      v   = shown[4*d +: 4];
      e_seg = (v < 10) ? SEG_TAB[v] : 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (shown >> (4 * d)) == 16'h0) e_seg = '0;
`endif
      e_sel = (off < B) ? 4'b0000 : 4'(1 << d);
    end
    exp_q.push_back({e_seg, e_sel, e_fd});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (seg !== e[11:5]) begin
        n_fail++;
        $display("FAIL seg t=%0d got=%b want=%b", t, seg, e[11:5]);
      end
      n_checks++;
      if (digit_sel !== e[4:1]) begin
        n_fail++;
        $display("FAIL digit_sel t=%0d got=%b want=%b", t, digit_sel, e[4:1]);
      end
      n_checks++;
      if (frame_done !== e[0]) begin
        n_fail++;
        $display("FAIL frame_done t=%0d got=%b want=%b", t, frame_done, e[0]);
      end
    end
  end

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return r;
  endfunction

  initial begin
    int guard;
    // reset held with en and load active
    rst = 1'b1; en = 1'b1; load = 1'b1; digits_in = 16'h9999;
    run(3);
    // scan 1234
    rst = 1'b0; en = 1'b0; load = 1'b1; digits_in = 16'h1234;
    step();
    load = 1'b0;
    step();
    en = 1'b1;
    run(2 * FRAME);
    // load during digit-1 slot must not tear the frame
    run(R + 3);
    load = 1'b1; digits_in = 16'h5678;
    step();
    load = 1'b0;
    run(2 * FRAME);
    // invalid BCD
    load = 1'b1; digits_in = 16'h00AF;
    step();
    load = 1'b0;
    run(2 * FRAME);
    // disable mid-frame and re-enable
    run(2 * R + 4);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(FRAME);
    // leading zeros
    en = 1'b0; load = 1'b1; digits_in = 16'h0040;
    step();
    load = 1'b0; en = 1'b1;
    run(FRAME + 2);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 19) != 0);
      load      = ($urandom_range(0, 9) == 0);
      digits_in = rand_digits();
      step();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
